// File: rtl/var_state_loader_if.sv
// Bundle of start/status, engine-state and memory-port signals for var_state_loader.
// master: the loader itself; slave: the surrounding controller, engine and memory.
interface var_state_loader_if #(
    parameter int unsigned NUM_VARS         = 8,
    parameter int unsigned WIDTH_VAR_STATES = 17,
    parameter int unsigned ADDR_WIDTH       = 12
);
    localparam int unsigned CntW = $clog2(NUM_VARS) + 1;

    logic                                 start_load_i;
    logic                                 start_store_i;
    logic [ADDR_WIDTH-1:0]                base_addr_i;
    logic [CntW-1:0]                      num_vars_i;
    logic                                 busy_o;
    logic                                 done_o;
    logic [NUM_VARS-1:0]                  wr_states_o;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i;
    logic                                 mem_rd_o;
    logic                                 mem_wr_o;
    logic [ADDR_WIDTH-1:0]                mem_addr_o;
    logic [WIDTH_VAR_STATES-1:0]          mem_wdata_o;
    logic [WIDTH_VAR_STATES-1:0]          mem_rdata_i;

    modport master (
        input  start_load_i, start_store_i, base_addr_i, num_vars_i, vars_states_i, mem_rdata_i,
        output busy_o, done_o, wr_states_o, vars_states_o, mem_rd_o, mem_wr_o, mem_addr_o,
               mem_wdata_o
    );

    modport slave (
        output start_load_i, start_store_i, base_addr_i, num_vars_i, vars_states_i, mem_rdata_i,
        input  busy_o, done_o, wr_states_o, vars_states_o, mem_rd_o, mem_wr_o, mem_addr_o,
               mem_wdata_o
    );
endinterface

// File: rtl/var_state_loader.sv
// Moves engine variable states between a global memory and the engine slot registers.
// Optional VAR_STATE_SKIP_UNCHANGED_EN: store skips slots still equal to their last loaded value.
module var_state_loader #(
    parameter int unsigned NUM_VARS         = 8,
    parameter int unsigned WIDTH_VAR_STATES = 17,
    parameter int unsigned ADDR_WIDTH       = 12
) (
    input logic               clk,
    input logic               rst,
    var_state_loader_if.master bus
);
    localparam int unsigned W  = WIDTH_VAR_STATES;
    localparam int unsigned CW = $clog2(NUM_VARS) + 1;
    localparam int unsigned SW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLdRd,
        StLdWait,
        StLdWr,
        StStCap,
        StStWr,
        StDone
    } state_e;

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mem_rd_q;
    logic                  mem_wr_q;
    logic                  rd_d1_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [W-1:0]          wdata_q;
    logic [NUM_VARS-1:0]   wr_states_q;
    logic [NUM_VARS*W-1:0] ld_buf_q;
    logic [NUM_VARS*W-1:0] st_buf_q;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         idx_q;
    logic [SW-1:0]         cap_idx_q;

    logic [CW-1:0]         n_req;
    logic [NUM_VARS-1:0]   ld_mask;
    logic [W-1:0]          eng_slot0;
    logic [W-1:0]          st_next;
    logic                  wr_first;
    logic                  wr_next;

    // Slot 0 sits in the most significant slice of the packed state vectors.
    function automatic logic [W-1:0] slot_of(input logic [NUM_VARS*W-1:0] v,
                                             input logic [SW-1:0] s);
        return v[(NUM_VARS-1-32'(s))*W +: W];
    endfunction

    assign n_req     = (bus.num_vars_i > CW'(NUM_VARS)) ? CW'(NUM_VARS) : bus.num_vars_i;
    assign eng_slot0 = slot_of(bus.vars_states_i, '0);
    assign st_next   = slot_of(st_buf_q, SW'(idx_q));

    always_comb begin
        ld_mask = '0;
        for (int unsigned s = 0; s < NUM_VARS; s++) begin
            if (s < 32'(n_q)) begin
                ld_mask[NUM_VARS-1-s] = 1'b1;
            end
        end
    end

`ifdef VAR_STATE_SKIP_UNCHANGED_EN
    logic [NUM_VARS*W-1:0] snap_q;
    logic [NUM_VARS-1:0]   snap_vld_q;

    // Address and cycle timing are kept; only the write strobe is dropped.
    assign wr_first = !(snap_vld_q[0] && (slot_of(snap_q, '0) == eng_slot0));
    assign wr_next  = !(snap_vld_q[SW'(idx_q)] && (slot_of(snap_q, SW'(idx_q)) == st_next));
`else
    assign wr_first = 1'b1;
    assign wr_next  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rd_d1_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_states_q <= '0;
            ld_buf_q    <= '0;
            st_buf_q    <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            cap_idx_q   <= '0;
`ifdef VAR_STATE_SKIP_UNCHANGED_EN
            snap_q      <= '0;
            snap_vld_q  <= '0;
`endif
        end else begin
            done_q      <= 1'b0;
            wr_states_q <= '0;
            // Read data returns one cycle after each strobe, in issue order.
            rd_d1_q     <= mem_rd_q;
            if (rd_d1_q) begin
                ld_buf_q[(NUM_VARS-1-32'(cap_idx_q))*W +: W] <= bus.mem_rdata_i;
                cap_idx_q <= cap_idx_q + SW'(1);
`ifdef VAR_STATE_SKIP_UNCHANGED_EN
                snap_q[(NUM_VARS-1-32'(cap_idx_q))*W +: W] <= bus.mem_rdata_i;
                snap_vld_q[cap_idx_q] <= 1'b1;
`endif
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start_load_i || bus.start_store_i) begin
                        busy_q <= 1'b1;
                        n_q    <= n_req;
                        addr_q <= bus.base_addr_i;
                        idx_q  <= CW'(1);
                        if (n_req == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
`ifdef VAR_STATE_SKIP_UNCHANGED_EN
                            if (bus.start_load_i) begin
                                snap_vld_q <= '0;
                            end
`endif
                        end else if (bus.start_load_i) begin
                            state_q   <= StLdRd;
                            mem_rd_q  <= 1'b1;
                            cap_idx_q <= '0;
                        end else begin
                            state_q <= StStCap;
                        end
                    end
                end
                StLdRd: begin
                    if (idx_q == n_q) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= StLdWait;
                    end else begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        idx_q  <= idx_q + CW'(1);
                    end
                end
                StLdWait: begin
                    // Last read word lands in the buffer on this edge.
                    state_q     <= StLdWr;
                    wr_states_q <= ld_mask;
                    done_q      <= 1'b1;
                end
                StLdWr: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                StStCap: begin
                    st_buf_q <= bus.vars_states_i;
                    wdata_q  <= eng_slot0;
                    mem_wr_q <= wr_first;
                    idx_q    <= CW'(1);
                    state_q  <= StStWr;
                end
                StStWr: begin
                    if (idx_q == n_q) begin
                        mem_wr_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        wdata_q  <= st_next;
                        mem_wr_q <= wr_next;
                        addr_q   <= addr_q + ADDR_WIDTH'(1);
                        idx_q    <= idx_q + CW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.wr_states_o   = wr_states_q;
    assign bus.vars_states_o = ld_buf_q;
    assign bus.mem_rd_o      = mem_rd_q;
    assign bus.mem_wr_o      = mem_wr_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_wdata_o   = wdata_q;
endmodule

// File: tb/tb_var_state_loader.sv
// Directed bench for var_state_loader: per-cycle trace of each operation checked against
// hand-computed timing, addresses and data.
module tb_var_state_loader;
    logic clk;
    logic rst;

    var_state_loader_if #(.NUM_VARS(8), .WIDTH_VAR_STATES(17), .ADDR_WIDTH(12)) bus ();

    var_state_loader #(
        .NUM_VARS        (8),
        .WIDTH_VAR_STATES(17),
        .ADDR_WIDTH      (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mutex_err = 0;

    // Memory model: untouched addresses return a fixed pattern, stores are recorded.
    logic [16:0] mem [4096];
    bit          wrote [4096];

    function automatic logic [16:0] init_val(input logic [11:0] a);
        if (a >= 12'h010 && a < 12'h018) return 17'(a - 12'h010) + 17'd1;
        if (a >= 12'h100 && a < 12'h108) return 17'(a);
        if (a == 12'h020) return 17'h00077;
        if (a == 12'h021) return 17'h00078;
        if (a >= 12'h200 && a < 12'h208) return 17'h00050 + 17'(a - 12'h200);
        return 17'h15555 ^ 17'(a);
    endfunction

    function automatic logic [16:0] mem_val(input logic [11:0] a);
        return wrote[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_o) bus.mem_rdata_i <= mem_val(bus.mem_addr_o);
        if (bus.mem_wr_o) begin
            mem[bus.mem_addr_o]   <= bus.mem_wdata_o;
            wrote[bus.mem_addr_o] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_rd_o && bus.mem_wr_o) mutex_err <= mutex_err + 1;
    end

    function automatic logic [135:0] put(input logic [135:0] v, input int k, input logic [16:0] x);
        v[(7-k)*17 +: 17] = x;
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle trace; index = cycle number relative to the start cycle 0.
    bit           tr_rd   [32];
    bit           tr_wr   [32];
    bit           tr_done [32];
    bit           tr_busy [32];
    logic [11:0]  tr_addr [32];
    logic [16:0]  tr_wdata[32];
    logic [7:0]   tr_wrs  [32];
    logic [135:0] tr_vs   [32];

    // Called #1 after a rising edge (that cycle is cycle 0).
    task automatic run_op(input bit ld, input bit st, input logic [11:0] base, input logic [3:0] n,
                          input int ncyc, input int st_again, input int rst_at);
        bus.start_load_i  = ld;
        bus.start_store_i = st;
        bus.base_addr_i   = base;
        bus.num_vars_i    = n;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start_load_i  = 1'b0;
            bus.start_store_i = (c == st_again);
            rst               = (c == rst_at);
            tr_rd[c]    = bus.mem_rd_o;
            tr_wr[c]    = bus.mem_wr_o;
            tr_done[c]  = bus.done_o;
            tr_busy[c]  = bus.busy_o;
            tr_addr[c]  = bus.mem_addr_o;
            tr_wdata[c] = bus.mem_wdata_o;
            tr_wrs[c]   = bus.wr_states_o;
            tr_vs[c]    = bus.vars_states_o;
        end
        bus.start_store_i = 1'b0;
        rst = 1'b0;
    endtask

    logic [135:0] exp_vs;
    logic [135:0] eng;
    logic [11:0]  a;
    bit           exp_wr;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.start_load_i  = 1'b0;
        bus.start_store_i = 1'b0;
        bus.base_addr_i   = '0;
        bus.num_vars_i    = '0;
        bus.vars_states_i = '0;
        bus.mem_rdata_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus.busy_o, bus.done_o, bus.mem_rd_o, bus.mem_wr_o, bus.wr_states_o}, 0);
        check("rst_addr", bus.mem_addr_o, 0);
        check("rst_wdata", bus.mem_wdata_o, 0);
        check("rst_vs", bus.vars_states_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full load, base 0x010, mem[0x010+k] = k+1.
        run_op(1'b1, 1'b0, 12'h010, 4'd8, 12, 0, 0);
        exp_vs = '0;
        for (int k = 0; k < 8; k++) exp_vs = put(exp_vs, k, 17'(k + 1));
        for (int c = 1; c <= 12; c++) begin
            check("ld8_rd", tr_rd[c], c <= 8);
            if (c <= 8) check("ld8_addr", tr_addr[c], 12'h010 + 12'(c - 1));
            check("ld8_wr", tr_wr[c], 0);
            check("ld8_done", tr_done[c], c == 10);
            check("ld8_busy", tr_busy[c], c <= 10);
            check("ld8_wrs", tr_wrs[c], (c == 10) ? 8'hFF : 8'h00);
        end
        check("ld8_vs", tr_vs[10], exp_vs);

        // Partial load N=3 leaves slots 3..7 untouched.
        run_op(1'b1, 1'b0, 12'h100, 4'd3, 7, 0, 0);
        for (int k = 0; k < 3; k++) exp_vs = put(exp_vs, k, 17'h100 + 17'(k));
        for (int c = 1; c <= 7; c++) begin
            check("ld3_rd", tr_rd[c], c <= 3);
            check("ld3_done", tr_done[c], c == 5);
            check("ld3_wrs", tr_wrs[c], (c == 5) ? 8'hE0 : 8'h00);
        end
        check("ld3_vs", tr_vs[5], exp_vs);
        repeat (3) @(posedge clk);
        #1;
        check("ld3_hold", bus.vars_states_o, exp_vs);

        // Store N=4 from 0xFFE wraps to 0x000.
        eng = '0;
        for (int k = 0; k < 8; k++) eng = put(eng, k, 17'h1A0 + 17'(k));
        bus.vars_states_i = eng;
        run_op(1'b0, 1'b1, 12'hFFE, 4'd4, 8, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            check("st4_wr", tr_wr[c], c >= 2 && c <= 5);
            check("st4_rd", tr_rd[c], 0);
            if (c >= 2 && c <= 5) begin
                a = 12'hFFE + 12'(c - 2);
                check("st4_addr", tr_addr[c], a);
                check("st4_wdata", tr_wdata[c], 17'h1A0 + 17'(c - 2));
            end
            check("st4_done", tr_done[c], c == 6);
            check("st4_busy", tr_busy[c], c <= 6);
            check("st4_wrs", tr_wrs[c], 0);
        end
        check("st4_mem_fff", mem_val(12'hFFF), 17'h1A1);
        check("st4_mem_001", mem_val(12'h001), 17'h1A3);
        check("st4_vs_hold", bus.vars_states_o, exp_vs);

        // Load and store together, then a store while busy: only the load runs.
        run_op(1'b1, 1'b1, 12'h020, 4'd2, 10, 3, 0);
        exp_vs = put(exp_vs, 0, 17'h00077);
        exp_vs = put(exp_vs, 1, 17'h00078);
        for (int c = 1; c <= 10; c++) begin
            check("both_wr", tr_wr[c], 0);
            check("both_rd", tr_rd[c], c <= 2);
            check("both_done", tr_done[c], c == 4);
            check("both_busy", tr_busy[c], c <= 4);
            check("both_wrs", tr_wrs[c], (c == 4) ? 8'hC0 : 8'h00);
        end
        check("both_vs", tr_vs[4], exp_vs);

        // N=0 load: done in cycle 1, no traffic.
        run_op(1'b1, 1'b0, 12'h300, 4'd0, 3, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            check("n0_rd", tr_rd[c], 0);
            check("n0_done", tr_done[c], c == 1);
            check("n0_busy", tr_busy[c], c == 1);
            check("n0_wrs", tr_wrs[c], 0);
        end
        check("n0_vs", tr_vs[2], exp_vs);

        // N=15 clamps to 8.
        eng = '0;
        for (int k = 0; k < 8; k++) eng = put(eng, k, 17'h1C0 + 17'(k));
        bus.vars_states_i = eng;
        run_op(1'b0, 1'b1, 12'h400, 4'd15, 11, 0, 0);
        for (int c = 1; c <= 11; c++) begin
            check("clamp_wr", tr_wr[c], c >= 2 && c <= 9);
            if (c >= 2 && c <= 9) begin
                check("clamp_addr", tr_addr[c], 12'h400 + 12'(c - 2));
                check("clamp_wdata", tr_wdata[c], 17'h1C0 + 17'(c - 2));
            end
            check("clamp_done", tr_done[c], c == 10);
        end

        // Reset in cycle 4 of an N=8 load aborts it.
        run_op(1'b1, 1'b0, 12'h010, 4'd8, 14, 0, 4);
        check("abort_c4_rd", tr_rd[4], 1);
        check("abort_c5_ctrl", {tr_busy[5], tr_done[5], tr_rd[5], tr_wr[5], tr_wrs[5]}, 0);
        check("abort_c5_addr", tr_addr[5], 0);
        check("abort_c5_wdata", tr_wdata[5], 0);
        check("abort_c5_vs", tr_vs[5], 0);
        for (int c = 1; c <= 14; c++) begin
            check("abort_done", tr_done[c], 0);
            check("abort_wrs", tr_wrs[c], 0);
            if (c >= 5) check("abort_rd", tr_rd[c], 0);
        end

        // Load 8, change slot 2 in the engine, store back.
        run_op(1'b1, 1'b0, 12'h200, 4'd8, 11, 0, 0);
        eng = '0;
        for (int k = 0; k < 8; k++) eng = put(eng, k, 17'h50 + 17'(k));
        check("skip_ld_vs", tr_vs[10], eng);
        eng = put(eng, 2, 17'h000AA);
        bus.vars_states_i = eng;
        run_op(1'b0, 1'b1, 12'h200, 4'd8, 11, 0, 0);
        for (int c = 1; c <= 11; c++) begin
`ifdef VAR_STATE_SKIP_UNCHANGED_EN
            exp_wr = (c == 4);
`else
            exp_wr = (c >= 2 && c <= 9);
`endif
            check("skip_wr", tr_wr[c], exp_wr);
            if (c >= 2 && c <= 9) check("skip_addr", tr_addr[c], 12'h200 + 12'(c - 2));
            if (exp_wr) check("skip_wdata", tr_wdata[c], (c == 4) ? 17'h000AA : 17'h50 + 17'(c - 2));
            check("skip_done", tr_done[c], c == 10);
        end

        check("mutex", mutex_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
